// File: rtl/pb_conditioner.sv
// pb_conditioner: synchronises and debounces the two active-low sequence
// keys, then turns clean presses into single-cycle active-low step pulses
// for the sequencer, with auto-repeat while exactly one key is held.
// Holding both keys suppresses all pulses until one of them is released.
module pb_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  output logic       pb_seq_up,
  output logic       pb_seq_dn,
  output logic [1:0] btn_held
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] T_ONE    = TW'(32'd1);
  localparam logic [TW-1:0] T_ZERO   = TW'(32'd0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BOTH   = 2'd2
  } state_t;

  // Bit 1 is the up key, bit 0 the down key, throughout.
  logic [1:0]    raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [CW-1:0] cnt_r [2];
  logic [1:0]    diff_s;
  logic [1:0]    flip_s;
  logic [1:0]    next_held_s;
  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic          req_up_r;
  logic          req_dn_r;

  assign raw_s = {key_up_n, key_dn_n};

  // Two-flop synchroniser per key; released (1) out of reset.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Detect disagreement with the stable level and the cycle the count completes.
  always_comb begin
    diff_s = 2'b00;
    flip_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      // Synchronised level is active-low, held level is active-high.
      diff_s[i] = ((~sync2_r[i]) != btn_held[i]);
      flip_s[i] = diff_s[i] && (cnt_r[i] == DB_LAST);
    end
  end

  assign next_held_s = btn_held ^ flip_s;

  // Debounce counters and stable levels; any agreement restarts the count.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      cnt_r[0] <= {CW{1'b0}};
      cnt_r[1] <= {CW{1'b0}};
      btn_held <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!diff_s[i] || flip_s[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      btn_held <= next_held_s;
    end
  end

  // Shared control: tracks how many keys are held, runs the repeat timer,
  // and raises a one-cycle pulse request on the edge a level change lands.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      timer_r  <= T_ZERO;
      req_up_r <= 1'b0;
      req_dn_r <= 1'b0;
    end else begin
      req_up_r <= 1'b0;
      req_dn_r <= 1'b0;
      case (next_held_s)
        2'b00: begin
          state_r <= ST_IDLE;
          timer_r <= T_ZERO;
        end
        2'b11: begin
          state_r <= ST_BOTH;
          timer_r <= T_ZERO;
        end
        default: begin
          state_r <= ST_SINGLE;
          if ((state_r == ST_SINGLE) && (next_held_s == btn_held)) begin
            // Same key still held: count down towards the next repeat.
            if (timer_r == T_ONE) begin
              req_up_r <= next_held_s[1];
              req_dn_r <= next_held_s[0];
              timer_r  <= T_PERIOD;
            end else if (timer_r != T_ZERO) begin
              timer_r <= timer_r - T_ONE;
            end else begin
              timer_r <= timer_r;
            end
          end else begin
            // Fresh single-key hold; only a real press (not leaving BOTH) pulses.
            timer_r <= T_DELAY;
            if (state_r != ST_BOTH) begin
              req_up_r <= next_held_s[1];
              req_dn_r <= next_held_s[0];
            end else begin
              req_up_r <= 1'b0;
              req_dn_r <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Registered active-low pulses; a request right after any low cycle is
  // dropped so the outputs are never low on consecutive cycles.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      pb_seq_up <= 1'b1;
      pb_seq_dn <= 1'b1;
    end else begin
      pb_seq_up <= ~(req_up_r & pb_seq_up & pb_seq_dn);
      pb_seq_dn <= ~(req_dn_r & pb_seq_up & pb_seq_dn);
    end
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Cycle n means the state sampled just after edge n, where
// edge 0 is the first edge to capture the new key level.
module tb_pb_conditioner;

  logic       CLK_50 = 1'b0;
  logic       reset;
  logic       key_up_n;
  logic       key_dn_n;
  logic       pb_seq_up;
  logic       pb_seq_dn;
  logic [1:0] btn_held;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int inv_bad = 0;
  logic prev_up_low = 1'b0;
  logic prev_dn_low = 1'b0;
  int up_q[$];
  int dn_q[$];
  int exp_rep[6] = '{6, 26, 34, 42, 50, 58};

  pb_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .CLK_50(CLK_50),
    .reset(reset),
    .key_up_n(key_up_n),
    .key_dn_n(key_dn_n),
    .pb_seq_up(pb_seq_up),
    .pb_seq_dn(pb_seq_dn),
    .btn_held(btn_held)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, log pulses and invariant breaks.
  task automatic tick();
    @(posedge CLK_50);
    #1;
    cyc++;
    if (!pb_seq_up) up_q.push_back(cyc);
    if (!pb_seq_dn) dn_q.push_back(cyc);
    if (!pb_seq_up && !pb_seq_dn) inv_bad++;
    if ((!pb_seq_up && prev_up_low) || (!pb_seq_dn && prev_dn_low)) inv_bad++;
    prev_up_low = !pb_seq_up;
    prev_dn_low = !pb_seq_dn;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    up_q.delete();
    dn_q.delete();
  endtask

  initial begin
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    chk("reset_up", {31'd0, pb_seq_up}, 32'd1);
    chk("reset_dn", {31'd0, pb_seq_dn}, 32'd1);
    chk("reset_held", {30'd0, btn_held}, 32'd0);
    reset = 1'b0;
    tick();

    // Clean press of up
    up_q.delete(); dn_q.delete();
    key_up_n = 1'b0; cyc = -1;
    run_to(4);
    chk("press_held_c4", {30'd0, btn_held}, 32'd0);
    run_to(5);
    chk("press_held_c5", {30'd0, btn_held}, 32'd2);
    run_to(12);
    chk("press_up_count", up_q.size(), 32'd1);
    chk("press_up_cycle", (up_q.size() > 0) ? up_q[0] : -1, 32'd6);
    chk("press_dn_count", dn_q.size(), 32'd0);
    key_up_n = 1'b1;
    run_to(40);
    chk("release_no_pulse", up_q.size(), 32'd1);
    chk("release_held", {30'd0, btn_held}, 32'd0);

    // Bouncing down key: never stable for 4 cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      key_dn_n = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    key_dn_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("bounce_held", {30'd0, btn_held}, 32'd0);
    chk("bounce_dn_count", dn_q.size(), 32'd0);
    chk("bounce_up_count", up_q.size(), 32'd0);

    // Auto-repeat while up is held for 60 cycles
    do_reset();
    key_up_n = 1'b0; cyc = -1;
    run_to(59);
    key_up_n = 1'b1;
    run_to(95);
    chk("repeat_count", up_q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("repeat_cycle%0d", i), (i < up_q.size()) ? up_q[i] : -1, exp_rep[i]);
    chk("repeat_dn_count", dn_q.size(), 32'd0);
    chk("repeat_held_end", {30'd0, btn_held}, 32'd0);

    // Both keys pressed together, then down released
    do_reset();
    key_up_n = 1'b0; key_dn_n = 1'b0; cyc = -1;
    run_to(4);
    chk("both_held_c4", {30'd0, btn_held}, 32'd0);
    run_to(5);
    chk("both_held_c5", {30'd0, btn_held}, 32'd3);
    run_to(19);
    key_dn_n = 1'b1;
    run_to(24);
    chk("both_held_c24", {30'd0, btn_held}, 32'd3);
    run_to(25);
    chk("both_held_c25", {30'd0, btn_held}, 32'd2);
    run_to(50);
    chk("both_up_count", up_q.size(), 32'd1);
    chk("both_up_cycle", (up_q.size() > 0) ? up_q[0] : -1, 32'd46);
    chk("both_dn_count", dn_q.size(), 32'd0);

    // Down pressed while up already held
    do_reset();
    key_up_n = 1'b0; cyc = -1;
    run_to(14);
    key_dn_n = 1'b0;
    run_to(60);
    chk("second_up_count", up_q.size(), 32'd1);
    chk("second_up_cycle", (up_q.size() > 0) ? up_q[0] : -1, 32'd6);
    chk("second_dn_count", dn_q.size(), 32'd0);
    chk("second_held", {30'd0, btn_held}, 32'd3);

    // Reset pulsed mid-hold, key stays held throughout
    do_reset();
    key_up_n = 1'b0; cyc = -1;
    run_to(9);
    chk("midrst_pre_count", up_q.size(), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_async_held", {30'd0, btn_held}, 32'd0);
    chk("midrst_async_up", {31'd0, pb_seq_up}, 32'd1);
    tick();
    chk("midrst_held", {30'd0, btn_held}, 32'd0);
    chk("midrst_dn", {31'd0, pb_seq_dn}, 32'd1);
    reset = 1'b0;
    up_q.delete();
    run_to(30);
    chk("midrst_post_count", up_q.size(), 32'd1);
    chk("midrst_post_cycle", (up_q.size() > 0) ? up_q[0] : -1, 32'd17);
    chk("midrst_held_end", {30'd0, btn_held}, 32'd2);

    // Output pulses never overlap and never last two cycles
    chk("invariant", inv_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
